// File: rtl/icache_pkg.sv
// icache_pkg: shared geometry, FSM state and block type for the instruction cache
package icache_pkg;
  localparam int ADDR_W = 10;
  localparam int NUM_BLOCKS = 8;
  localparam int BLOCK_WORDS = 4;
  localparam int IDX_W = 3;
  localparam int OFF_W = 2;
  localparam int IDX_LSB = 4;
  localparam int TAG_W = ADDR_W - IDX_W - IDX_LSB;
  localparam int BADDR_W = TAG_W + IDX_W;
  localparam int BLOCK_BITS = 32 * BLOCK_WORDS;
  typedef enum logic {IDLE, MEM_READ} state_t;
  typedef logic [BLOCK_BITS-1:0] block_t;
endpackage

// File: rtl/icache_line_array.sv
// icache_line_array: per-line valid/tag/data storage, sync write, async read, sync clear
module icache_line_array
  import icache_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  block_t           wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output block_t           rdata
);
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0] tags [NUM_BLOCKS];
  block_t data [NUM_BLOCKS];
  // valid bits: reset wins over a fill landing on the same edge
  always_ff @(posedge CLK) begin
    if (RESET) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end
  // tag/data payload, only meaningful once the line is valid
  always_ff @(posedge CLK) begin
    if (we && !RESET) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  end
  assign rvalid = valid[ridx];
  assign rtag = tags[ridx];
  assign rdata = data[ridx];
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only I-cache; ICACHE_STATS_EN adds hit/miss counters
module instr_cache
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        PC,
  input  logic               READ,
  output logic [31:0]        INSTRUCTION,
  output logic               BUSYWAIT,
  output logic               mem_read,
  output logic [BADDR_W-1:0] mem_address,
  input  block_t             mem_readdata,
  input  logic               mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);
  state_t state, next_state;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] off;
  logic line_valid, hit, fill, miss_start;
  logic [TAG_W-1:0] line_tag;
  block_t line_data;
  logic unused_pc;
  assign idx = PC[IDX_LSB +: IDX_W];
  assign tag = PC[ADDR_W-1 -: TAG_W];
  assign off = PC[IDX_LSB-1 -: OFF_W];
  assign unused_pc = ^{PC[31:ADDR_W], PC[1:0]};
  icache_line_array u_lines (
    .CLK(CLK),
    .RESET(RESET),
    .we(fill),
    .widx(mem_address[IDX_W-1:0]),
    .wtag(mem_address[BADDR_W-1 -: TAG_W]),
    .wdata(mem_readdata),
    .ridx(idx),
    .rvalid(line_valid),
    .rtag(line_tag),
    .rdata(line_data)
  );
  assign hit = READ && line_valid && (line_tag == tag);
  assign miss_start = (state == IDLE) && READ && !hit;
  assign INSTRUCTION = hit ? line_data[{off, 5'd0} +: 32] : 32'h0;
  // state and the latched block address; the fill always targets this latched line
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      mem_address <= '0;
    end else begin
      state <= next_state;
      if (miss_start) mem_address <= PC[ADDR_W-1:IDX_LSB];
    end
  end
  // next state, stall and memory handshake
  always_comb begin
    next_state = state;
    BUSYWAIT = 1'b0;
    mem_read = 1'b0;
    fill = 1'b0;
    if (state == IDLE) begin
      BUSYWAIT = miss_start;
      if (miss_start) next_state = MEM_READ;
    end else begin
      BUSYWAIT = 1'b1;
      mem_read = 1'b1;
      fill = !mem_busywait;
      if (!mem_busywait) next_state = IDLE;
    end
  end
`ifdef ICACHE_STATS_EN
  // saturating hit/miss counters
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (state == IDLE && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (miss_start && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule
